// File: rtl/qam_src_pkg.sv
// Shared definitions for the QAM test-data source: source-select encodings
// and the PRBS-15 generator constants.
package qam_src_pkg;

   typedef enum logic [1:0] {
      MODE_PATTERN = 2'd0,
      MODE_PRBS    = 2'd1,
      MODE_COUNT   = 2'd2,
      MODE_ZERO    = 2'd3
   } mode_e;

   // x^15 + x^14 + 1 in Fibonacci form: feedback taps are state bits 14 and 13
   localparam int          PRBS_W            = 15;
   localparam int          PRBS_TAP_HI       = 14;
   localparam int          PRBS_TAP_LO       = 13;
   localparam logic [14:0] PRBS_DEFAULT_SEED = 15'h7FFF;

endpackage

// File: rtl/qam_data_source_prbs_stepper.sv
// Combinational PRBS-15 advance by STEPS bit-steps in one cycle; the earliest
// generated bit lands in o_bits[0].
module prbs_stepper
   import qam_src_pkg::*;
#(
   parameter int STEPS = 4
) (
   input  logic [PRBS_W-1:0] i_state,
   output logic [PRBS_W-1:0] o_next_state,
   output logic [STEPS-1:0]  o_bits
);

   always_comb begin
      logic [PRBS_W-1:0] w_walk;
      w_walk = i_state;
      o_bits = '0;
      for (int k = 0; k < STEPS; k++) begin
         o_bits[k] = w_walk[PRBS_TAP_HI] ^ w_walk[PRBS_TAP_LO];
         w_walk    = {w_walk[PRBS_W-2:0], o_bits[k]};
      end
      o_next_state = w_walk;
   end

endmodule

// File: rtl/qam_data_source.sv
// Test-data source for the 16-QAM mapper: one SYM_W-bit word per INTERVAL
// clocks from a selectable source, with valid/ready handshake and drop flag.
module qam_data_source
   import qam_src_pkg::*;
#(
   parameter int                   PATTERN_W    = 64,
   parameter int                   SYM_W        = 4,
   parameter int                   INTERVAL     = 1020,
   parameter logic [PATTERN_W-1:0] PATTERN_INIT = 64'hB9A8_3120_7564_FDEC,
   parameter logic [PRBS_W-1:0]    PRBS_SEED    = PRBS_DEFAULT_SEED
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [1:0]           mode,
   input  logic                 load_pattern,
   input  logic [PATTERN_W-1:0] pattern_in,
   output logic [SYM_W-1:0]     data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 overflow,
   input  logic                 clr_overflow,
   output logic [15:0]          word_count
);

   localparam int               CNT_W    = $clog2(INTERVAL);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERVAL - 1);

   logic [CNT_W-1:0]     r_cnt;
   logic [PATTERN_W-1:0] r_pattern;
   logic [PRBS_W-1:0]    r_lfsr;
   logic [SYM_W-1:0]     r_count;
   logic [SYM_W-1:0]     r_data;
   logic                 r_valid;
   logic                 r_overflow;
   logic [15:0]          r_word_count;

   mode_e                w_mode;
   logic                 w_tick;
   logic                 w_xfer;
   logic                 w_accept;
   logic                 w_drop;
   logic [SYM_W-1:0]     w_word;
   logic [PATTERN_W-1:0] w_pattern_next;
   logic [PRBS_W-1:0]    w_lfsr_next;
   logic [SYM_W-1:0]     w_count_next;
   logic [PRBS_W-1:0]    w_prbs_state;
   logic [SYM_W-1:0]     w_prbs_bits;

   assign w_mode   = mode_e'(mode);
   // A pattern load restarts the interval, so it swallows a coincident tick
   assign w_tick   = enable && (r_cnt == CNT_LAST) && !load_pattern;
   assign w_xfer   = r_valid && data_ready;
   assign w_accept = w_tick && (!r_valid || w_xfer);
   assign w_drop   = w_tick && r_valid && !data_ready;

   prbs_stepper #(
      .STEPS(SYM_W)
   ) u_prbs (
      .i_state     (r_lfsr),
      .o_next_state(w_prbs_state),
      .o_bits      (w_prbs_bits)
   );

   always_comb begin
      w_word         = '0;
      w_pattern_next = r_pattern;
      w_lfsr_next    = r_lfsr;
      w_count_next   = r_count;
      if (w_accept) begin
         unique case (w_mode)
            MODE_PATTERN: begin
               w_word         = r_pattern[SYM_W-1:0];
               w_pattern_next = {r_pattern[SYM_W-1:0], r_pattern[PATTERN_W-1:SYM_W]};
            end
            MODE_PRBS: begin
               w_word      = w_prbs_bits;
               w_lfsr_next = w_prbs_state;
            end
            MODE_COUNT: begin
               w_word       = r_count;
               w_count_next = r_count + 1'b1;
            end
            MODE_ZERO: begin
               w_word = '0;
            end
            default: begin
               w_word = '0;
            end
         endcase
      end
      if (load_pattern) begin
         w_pattern_next = pattern_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (load_pattern) begin
         r_cnt <= '0;
      end else if (enable) begin
         r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pattern <= PATTERN_INIT;
         r_lfsr    <= PRBS_SEED;
         r_count   <= '0;
      end else begin
         r_pattern <= w_pattern_next;
         r_lfsr    <= w_lfsr_next;
         r_count   <= w_count_next;
      end
   end

   // A dropped tick leaves data_out and data_valid untouched
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_word_count <= '0;
      end else if (w_accept) begin
         r_data       <= w_word;
         r_valid      <= 1'b1;
         r_word_count <= r_word_count + 16'd1;
      end else if (w_xfer) begin
         r_valid      <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (clr_overflow) begin
         r_overflow <= 1'b0;
      end
   end

   assign data_out   = r_data;
   assign data_valid = r_valid;
   assign overflow   = r_overflow;
   assign word_count = r_word_count;

endmodule

// File: tb/tb_qam_data_source.sv
// Scoreboard bench for qam_data_source: a behavioural model predicts every
// accepted word and per-cycle status; a monitor checks each transferred word.
module tb_qam_data_source;

   localparam int          PW       = 64;
   localparam int          SW       = 4;
   localparam int          INTERVAL = 8;
   localparam logic [63:0] PINIT    = 64'hB9A8_3120_7564_FDEC;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic          load_pattern = 1'b0;
   logic [PW-1:0] pattern_in = '0;
   logic [SW-1:0] data_out;
   logic          data_valid;
   logic          data_ready = 1'b0;
   logic          overflow;
   logic          clr_overflow = 1'b0;
   logic [15:0]   word_count;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state
   int            mPhase;
   logic [PW-1:0] mPattern;
   logic [14:0]   mLfsr;
   int            mCount;
   logic [SW-1:0] mData;
   bit            mValid;
   bit            mOverflow;
   int            mWords;

   logic [SW-1:0] expQ[$];
   logic [SW-1:0] gotWords[$];

   qam_data_source #(
      .PATTERN_W   (PW),
      .SYM_W       (SW),
      .INTERVAL    (INTERVAL),
      .PATTERN_INIT(PINIT),
      .PRBS_SEED   (15'h7FFF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .mode        (mode),
      .load_pattern(load_pattern),
      .pattern_in  (pattern_in),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .overflow    (overflow),
      .clr_overflow(clr_overflow),
      .word_count  (word_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      mPhase    = 0;
      mPattern  = PINIT;
      mLfsr     = 15'h7FFF;
      mCount    = 0;
      mData     = '0;
      mValid    = 0;
      mOverflow = 0;
      mWords    = 0;
      expQ.delete();
   endtask

   // Next word from the selected source, advancing only that source
   task automatic produceWord(output logic [SW-1:0] w);
      logic fb;
      w = '0;
      case (mode)
         2'd0: begin
            w        = mPattern[SW-1:0];
            mPattern = (mPattern >> SW) | (mPattern << (PW - SW));
         end
         2'd1: begin
            for (int i = 0; i < SW; i++) begin
               fb    = mLfsr[14] ^ mLfsr[13];
               mLfsr = {mLfsr[13:0], fb};
               w[i]  = fb;
            end
         end
         2'd2: begin
            w      = SW'(mCount);
            mCount = (mCount + 1) % (1 << SW);
         end
         default: w = '0;
      endcase
   endtask

   // Predict the effect of the current inputs, clock once, then compare status
   task automatic applyStimulus();
      bit            tick, xfer, accept, drop;
      logic [SW-1:0] w;
      if (rst) begin
         modelReset();
      end else begin
         tick   = enable && (mPhase == INTERVAL - 1) && !load_pattern;
         xfer   = mValid && data_ready;
         accept = tick && (!mValid || xfer);
         drop   = tick && mValid && !xfer;
         if (accept) begin
            produceWord(w);
            expQ.push_back(w);
            mData  = w;
            mWords = (mWords + 1) % 65536;
         end
         if (accept)     mValid = 1;
         else if (xfer)  mValid = 0;
         if (drop)              mOverflow = 1;
         else if (clr_overflow) mOverflow = 0;
         if (load_pattern) begin
            mPattern = pattern_in;
            mPhase   = 0;
         end else if (enable) begin
            mPhase = (mPhase + 1) % INTERVAL;
         end
      end
      @(posedge clk);
      #1;
      checkOutput("data_valid", 64'(data_valid), 64'(mValid));
      checkOutput("overflow", 64'(overflow), 64'(mOverflow));
      checkOutput("word_count", 64'(word_count), 64'(mWords));
      checkOutput("data_out", 64'(data_out), 64'(mData));
   endtask

   task automatic doReset();
      rst          = 1'b1;
      enable       = 1'b0;
      load_pattern = 1'b0;
      clr_overflow = 1'b0;
      data_ready   = 1'b0;
      applyStimulus();
      checkOutput("reset_valid", 64'(data_valid), 64'd0);
      checkOutput("reset_data", 64'(data_out), 64'd0);
      checkOutput("reset_overflow", 64'(overflow), 64'd0);
      checkOutput("reset_count", 64'(word_count), 64'd0);
      rst = 1'b0;
   endtask

   task automatic waitValid(input int budget, output int cycles);
      cycles = 0;
      while (!data_valid && cycles < budget) begin
         applyStimulus();
         cycles++;
      end
      if (!data_valid) checkOutput("wait_valid_timeout", 64'd0, 64'd1);
   endtask

   task automatic waitWords(input int n, input int budget);
      int c = 0;
      while (gotWords.size() < n && c < budget) begin
         applyStimulus();
         c++;
      end
      if (gotWords.size() < n) checkOutput("wait_words_timeout", 64'(gotWords.size()), 64'(n));
   endtask

   // Monitor: a word is consumed on the next edge whenever valid and ready are high
   always @(negedge clk) begin
      if (!rst && data_valid && data_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_word", 64'(data_out), 64'hFFFF);
         end else begin
            checkOutput("scoreboard_word", 64'(data_out), 64'(expQ.pop_front()));
         end
         gotWords.push_back(data_out);
      end
   end

   initial begin
      int            cyc;
      logic [SW-1:0] patSeq[8];
      logic [SW-1:0] tmp;
      patSeq = '{4'hC, 4'hE, 4'hD, 4'hF, 4'h4, 4'h6, 4'h5, 4'h7};
      modelReset();

      $display("[TB] pattern mode, free-running consumer");
      doReset();
      enable = 1; mode = 2'd0; data_ready = 1;
      waitValid(50, cyc);
      checkOutput("first_valid_latency", 64'(cyc), 64'(INTERVAL));
      waitWords(17, 400);
      if (gotWords.size() >= 17) begin
         for (int i = 0; i < 8; i++) checkOutput("pattern_seq", 64'(gotWords[i]), 64'(patSeq[i]));
         checkOutput("pattern_period", 64'(gotWords[16]), 64'hC);
      end

      $display("[TB] PRBS-15 mode");
      doReset();
      gotWords.delete();
      enable = 1; mode = 2'd1; data_ready = 1;
      waitWords(200, 200 * INTERVAL + 50);
      if (gotWords.size() >= 4) begin
         checkOutput("prbs_w0", 64'(gotWords[0]), 64'h0);
         checkOutput("prbs_w1", 64'(gotWords[1]), 64'h0);
         checkOutput("prbs_w2", 64'(gotWords[2]), 64'h0);
         checkOutput("prbs_w3", 64'(gotWords[3]), 64'h4);
      end

      $display("[TB] stalled consumer and overflow");
      doReset();
      enable = 1; mode = 2'd2; data_ready = 0;
      waitValid(50, cyc);
      for (int i = 0; i < INTERVAL; i++) applyStimulus();
      checkOutput("ovf_after_second_tick", 64'(overflow), 64'd1);
      checkOutput("ovf_word_count", 64'(word_count), 64'd1);
      checkOutput("ovf_held_word", 64'(data_out), 64'd0);
      for (int i = 0; i < INTERVAL; i++) applyStimulus();
      clr_overflow = 1;
      applyStimulus();
      clr_overflow = 0;
      checkOutput("ovf_cleared", 64'(overflow), 64'd0);

      $display("[TB] tick coincident with transfer");
      doReset();
      enable = 1; mode = 2'd2; data_ready = 0;
      waitValid(50, cyc);
      cyc = 0;
      while (mPhase != INTERVAL - 1 && cyc < 2 * INTERVAL) begin
         applyStimulus();
         cyc++;
      end
      data_ready = 1;
      applyStimulus();
      checkOutput("same_edge_valid", 64'(data_valid), 64'd1);
      checkOutput("same_edge_word", 64'(data_out), 64'd1);
      checkOutput("same_edge_overflow", 64'(overflow), 64'd0);

      $display("[TB] pattern load mid-interval");
      doReset();
      enable = 1; mode = 2'd0; data_ready = 1;
      for (int i = 0; i < 3; i++) applyStimulus();
      gotWords.delete();
      load_pattern = 1; pattern_in = 64'h0123_4567_89AB_CDEF;
      applyStimulus();
      load_pattern = 0;
      waitValid(50, cyc);
      checkOutput("load_latency", 64'(cyc), 64'(INTERVAL));
      waitWords(3, 100);
      if (gotWords.size() >= 3) begin
         checkOutput("load_w0", 64'(gotWords[0]), 64'hF);
         checkOutput("load_w1", 64'(gotWords[1]), 64'hE);
         checkOutput("load_w2", 64'(gotWords[2]), 64'hD);
      end

      $display("[TB] randomized traffic");
      doReset();
      for (int i = 0; i < 1500; i++) begin
         enable       = ($urandom_range(0, 9) != 0);
         data_ready   = ($urandom_range(0, 9) < 6);
         clr_overflow = ($urandom_range(0, 19) == 0);
         load_pattern = ($urandom_range(0, 49) == 0);
         pattern_in   = {$urandom, $urandom};
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         applyStimulus();
      end
      load_pattern = 0; clr_overflow = 0;

      $display("[TB] asynchronous reset with a pending word");
      doReset();
      enable = 1; mode = 2'd0; data_ready = 0;
      waitValid(50, cyc);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_rst_valid", 64'(data_valid), 64'd0);
      checkOutput("async_rst_data", 64'(data_out), 64'd0);
      checkOutput("async_rst_count", 64'(word_count), 64'd0);
      modelReset();
      doReset();
      gotWords.delete();
      enable = 1; mode = 2'd0; data_ready = 1;
      waitWords(2, 100);
      if (gotWords.size() >= 2) begin
         tmp = gotWords[0];
         checkOutput("restart_w0", 64'(tmp), 64'hC);
         checkOutput("restart_w1", 64'(gotWords[1]), 64'hE);
      end

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/qam_data_source.md
Name: qam_data_source

Overview:
- Parametrised test-data source feeding the 16-QAM transmitter's symbol mapper.
- Emits one SYM_W-bit word every INTERVAL clocks, from one of four sources: loadable rotating pattern, PRBS-15, counting sequence, or constant zero.
- Adds a valid/ready handshake and overflow detection to the previous fixed-pattern, serial-only generator.
- Sits between the transmitter control logic and the mapper or serialiser.

Parameters:
- PATTERN_W, 64, rotating-pattern register width; must be a multiple of SYM_W.
- SYM_W, 4, bits per output word (4 = one 16-QAM symbol).
- INTERVAL, 1020, clocks between word ticks; must be at least 2.
- PATTERN_INIT, 64'hB9A8_3120_7564_FDEC, pattern register value after reset.
- PRBS_SEED, 15'h7FFF, LFSR value after reset; must be nonzero.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  interval counter runs only while high.
- mode  in  2  0 = pattern, 1 = PRBS-15, 2 = count, 3 = zero.
- load_pattern  in  1  one-cycle pulse: load pattern_in.
- pattern_in  in  PATTERN_W  new pattern value.
- data_out  out  SYM_W  current word.
- data_valid  out  1  data_out holds an untransferred word.
- data_ready  in  1  consumer accepts the word.
- overflow  out  1  sticky: a tick was dropped.
- clr_overflow  in  1  clears overflow.
- word_count  out  16  words generated since reset; wraps.

Behaviour:
- Reset (asynchronous, active-high): interval counter = 0, pattern = PATTERN_INIT, LFSR = PRBS_SEED, count register = 0, data_out = 0, data_valid = 0, overflow = 0, word_count = 0.
- Interval counter:
  - Increments while enable = 1; wraps INTERVAL-1 to 0.
  - tick = enable and counter == INTERVAL-1.
  - With enable = 0 the counter holds and no tick occurs.
- First word: data_valid rises on the edge after the INTERVAL-th enabled clock. Latency from tick to output is 1 clock.
- Transfer: occurs on any edge where data_valid = 1 and data_ready = 1. data_valid falls unless a tick is accepted on the same edge.
- Tick accepted when data_valid = 0 or a transfer occurs on the same edge:
  - data_out is loaded and data_valid = 1.
  - The selected source advances.
  - word_count increments.
- Tick while data_valid = 1 and no transfer:
  - Tick dropped; source and data_out are unchanged.
  - overflow is set.
  - data_valid stays 1.
- mode 0 (pattern): data_out <= pattern[SYM_W-1:0]; pattern rotates right by SYM_W. Full period is PATTERN_W/SYM_W words.
- mode 1 (PRBS-15):
  - Polynomial x^15 + x^14 + 1, Fibonacci form.
  - One step: fb = s[14] ^ s[13]; s <= {s[13:0], fb}; the output bit is fb.
  - SYM_W steps per tick, unrolled into one cycle.
  - The earliest output bit goes to data_out[0].
- mode 2 (count): data_out <= count register; count register increments modulo 2^SYM_W.
- mode 3 (zero): data_out <= 0.
- Only the selected source advances; unselected sources hold their state.
- mode is sampled only at an accepted tick. A mid-interval change has no effect until then.
- load_pattern:
  - Loads pattern_in into the pattern register and clears the interval counter.
  - A tick on the same edge is suppressed.
  - Does not affect the LFSR, data_valid, or a pending word.
- clr_overflow: clears overflow. If a drop occurs on the same edge, set wins.
- enable falling with a word pending: data_valid and data_out hold, and the word remains transferable.
- Reset mid-word: everything returns to reset values immediately; the pending word is lost.

Decomposition:
- Shared package qam_src_pkg: mode encodings (MODE_PATTERN, MODE_PRBS, MODE_COUNT, MODE_ZERO), PRBS-15 tap constants, default PRBS_SEED.
- Sub-module prbs_stepper: combinational, parametrised by step count. Inputs: 15-bit state. Outputs: next state and STEPS output bits. Instantiated with STEPS = SYM_W.

Test Plan:
- SYM_W=4, INTERVAL=8, mode 0, data_ready=1, enable held high after reset: first data_valid 8 clocks later; data_out sequence C, E, D, F, 4, 6, 5, 7; the pattern repeats after 16 words.
- Mode 1 with default seed: words 0, 1, 2 = 4'h0; word 3 = 4'h4. Compare 200 words against a bit-serial PRBS-15 model.
- data_ready=0 for 3 intervals: first word is held; overflow = 1 after the second tick; word_count = 1. Then clr_overflow -> overflow = 0.
- Tick and transfer on the same edge: data_valid stays 1, the new word appears, overflow stays 0.
- load_pattern 64'h0123_4567_89AB_CDEF mid-interval: the next word appears INTERVAL clocks after the pulse and equals 4'hF, followed by E, D.
- rst asserted mid-interval while data_valid=1: all outputs go to 0 asynchronously. After release, the mode 0 sequence restarts at C.
